legv8_datapath_mc: RTL
======================

# legv8_datapath_mc

Parametrised multi-cycle LEGv8 datapath: register file, ALU, status register, PC and IR, driven by a control word under a valid/ready handshake. Replaces the single-cycle tri-state bus with point-to-point muxes and a split memory port with req/ack wait states. Sits between the control unit (supplies control words and K) and the unified memory controller. Each control word completes fully (commits) before the next is accepted.

## Interface
- DATA_W, 64, datapath and register width (≥ 32).
- ADDR_W, 32, memory address and PC width (≤ DATA_W).
- REG_CNT, 32, register count, power of two; SEL_W = $clog2(REG_CNT); highest index is XZR.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- cw  in  CW_W = 18+3·SEL_W  control word, MSB first: FS[4:0], SA, SB, DA, w_reg, C0, B_sel, mem_rd, mem_wr, IR_load, status_load, addr_sel, data_sel[1:0], PC_sel, PC_FS[1:0].
- k  in  ADDR_W  immediate, zero-extended to DATA_W for the B mux.
- cw_valid  in  1  cw/k valid.
- cw_ready  out  1  datapath can accept cw.
- done  out  1  one-cycle pulse on the commit cycle.
- mem_req / mem_we  out  1  memory request / write.
- mem_addr  out  ADDR_W  addr_sel=0: PC; 1: ALU[ADDR_W-1:0].
- mem_wdata  out  DATA_W  register B.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  completes the request.
- status  out  4  {V,C,N,Z} register.
- IR_out  out  32  instruction register.
- PC_out  out  ADDR_W  program counter.

## Operation
- Latch cw and k on accept; all decoding uses the latched copy.
- FSM states: IDLE, EXEC, MEM_WAIT, WB.
- IDLE: cw_ready=1; accepting moves to EXEC.
- EXEC: A=R[SA], B=B_sel ? k : R[SB]; ALU result and flags registered at end of cycle. mem_rd|mem_wr → MEM_WAIT; otherwise → WB.
- MEM_WAIT: mem_req=1 with mem_we=mem_wr and stable addr/wdata until mem_ack; on ack capture mem_rdata → WB. mem_rd and mem_wr both set: treat as write (mem_we=1), rdata still captured.
- WB (commit, done=1) → IDLE. Write-back data: data_sel 0 ALU, 1 B, 2 PC+4 (zero-extended), 3 captured rdata.
  - w_reg: R[DA] ← data; DA = XZR ignored. XZR always reads 0.
  - IR_load: IR ← data[31:0]. status_load: status ← flags.
  - PC_FS: 00 hold, 01 PC+4, 10 PC ← (PC_sel ? k : A[ADDR_W-1:0]), 11 PC ← PC+4+(k<<2). All modulo 2^ADDR_W.
- ALU: A' = FS[1] ? ~A : A, B' = FS[0] ? ~B : B. FS[4:2]: 000 AND, 001 OR, 010 A'+B'+C0, 011 XOR, 100 A<<B[5:0], 101 A>>B[5:0] (logical), 110 pass B', 111 0. Shift amounts ≥ DATA_W yield 0.
- Flags: N=F[DATA_W-1], Z=(F==0); C = carry-out, V = signed overflow for op 010; C=V=0 otherwise.

## Timing
- Reset: all registers, PC, IR, status = 0; FSM IDLE; cw_ready=1, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset during MEM_WAIT: mem_req low the next cycle; the pending ack is ignored; nothing commits.
- Latency accept→done: 2 cycles without memory; 2+N+1 with memory, where N ≥ 1 is cycles from mem_req rising to mem_ack sampled high (ack in first cycle gives 4).
- mem_ack outside MEM_WAIT is ignored. cw_valid while cw_ready=0 is ignored (not queued).
- Earliest next accept: cycle after done.

## Configuration
- LEGV8_DATAPATH_BYPASS_EN defined: non-memory control words commit at the end of EXEC (done in EXEC, WB skipped), latency 1; memory ops unchanged.
- Undefined: all control words pass through WB as above.

## Test plan
- Reset, then cw R1←k (B_sel=1, FS=110, data_sel=0, w_reg, DA=1), k=5 → done 2 cycles after accept, R1=5, status unchanged 0.
- R1=5, R2=7, ADD with status_load, DA=3 → R3=12, status=0000; R1=0x7FFF_FFFF_FFFF_FFFF+1 → status V=1,N=1 (1010).
- Load, mem_ack held off 3 cycles, rdata 0xDEAD_BEEF, data_sel=3, DA=4 → mem_req high 3 cycles with stable addr, R4=0xDEAD_BEEF, done 6 cycles after accept.
- Write DA=XZR with k=9, then read XZR via pass B' with SB=XZR → result 0.
- PC=8, PC_FS=11, k=0xFFFF_FFFF (ADDR_W=32) → PC = 8+4−4 = 8 (wrap); PC_FS=01 at PC=0xFFFF_FFFC → PC=0.
- Reset asserted in MEM_WAIT then ack → mem_req=0 next cycle, no register change, cw_ready=1; repeat with macro defined and check 1-cycle non-memory latency.

Source files
------------

// File: rtl/legv8_datapath_mc.sv
// Multi-cycle LEGv8 datapath: register file, ALU, status, PC and IR under a cw handshake.
// Optional LEGV8_DATAPATH_BYPASS_EN: non-memory control words commit at the end of EXEC.
module legv8_datapath_mc #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned REG_CNT = 32,
    localparam int unsigned SEL_W  = $clog2(REG_CNT),
    localparam int unsigned CW_W   = 18 + 3 * SEL_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CW_W-1:0]   cw,
    input  logic [ADDR_W-1:0] k,
    input  logic              cw_valid,
    output logic              cw_ready,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [3:0]        status,
    output logic [31:0]       IR_out,
    output logic [ADDR_W-1:0] PC_out
);
    localparam logic [SEL_W-1:0] XZR = SEL_W'(REG_CNT - 1);

    typedef enum logic [1:0] {StIdle, StExec, StMemWait, StWb} state_e;
    state_e state_q, state_d;

    logic [CW_W-1:0]   cw_q;
    logic [ADDR_W-1:0] k_q, a_q, pc_q;
    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] b_q, alu_q, rdata_q;
    logic [3:0]        flags_q, status_q;
    logic [31:0]       ir_q;
    logic              req_q;

    logic [4:0]       fs;
    logic [SEL_W-1:0] sa, sb, da;
    logic w_reg, c0, b_sel, mem_rd, mem_wr, ir_load, st_load, addr_sel, pc_sel;
    logic [1:0] data_sel, pc_fs;

    assign fs       = cw_q[CW_W-1 -: 5];
    assign sa       = cw_q[13 + 2 * SEL_W +: SEL_W];
    assign sb       = cw_q[13 + SEL_W +: SEL_W];
    assign da       = cw_q[13 +: SEL_W];
    assign w_reg    = cw_q[12];
    assign c0       = cw_q[11];
    assign b_sel    = cw_q[10];
    assign mem_rd   = cw_q[9];
    assign mem_wr   = cw_q[8];
    assign ir_load  = cw_q[7];
    assign st_load  = cw_q[6];
    assign addr_sel = cw_q[5];
    assign data_sel = cw_q[4:3];
    assign pc_sel   = cw_q[2];
    assign pc_fs    = cw_q[1:0];

    logic [DATA_W-1:0] a_rd, b_rd, b_mux, a_m, b_m, f;
    logic [DATA_W:0]   sum;
    logic [5:0]        sh;
    logic              c_flag, v_flag;
    logic [3:0]        flags_c;

    assign a_rd  = (sa == XZR) ? '0 : regs_q[sa];
    assign b_rd  = (sb == XZR) ? '0 : regs_q[sb];
    assign b_mux = b_sel ? DATA_W'(k_q) : b_rd;
    assign a_m   = fs[1] ? ~a_rd : a_rd;
    assign b_m   = fs[0] ? ~b_mux : b_mux;
    assign sum   = {1'b0, a_m} + {1'b0, b_m} + {{DATA_W{1'b0}}, c0};
    assign sh    = b_m[5:0];

    always_comb begin
        f      = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        unique case (fs[4:2])
            3'b000: f = a_m & b_m;
            3'b001: f = a_m | b_m;
            3'b010: begin
                f      = sum[DATA_W-1:0];
                c_flag = sum[DATA_W];
                v_flag = (a_m[DATA_W-1] == b_m[DATA_W-1]) && (sum[DATA_W-1] != a_m[DATA_W-1]);
            end
            3'b011: f = a_m ^ b_m;
            3'b100: f = (32'(sh) >= DATA_W) ? '0 : (a_m << sh);
            3'b101: f = (32'(sh) >= DATA_W) ? '0 : (a_m >> sh);
            3'b110: f = b_m;
            default: f = '0;
        endcase
    end

    assign flags_c = {v_flag, c_flag, f[DATA_W-1], f == '0};

    // Bypass commits straight from the EXEC-cycle combinational results.
    logic bypass;
`ifdef LEGV8_DATAPATH_BYPASS_EN
    assign bypass = (state_q == StExec) && !(mem_rd || mem_wr);
`else
    assign bypass = 1'b0;
`endif

    logic [DATA_W-1:0] wb_alu, wb_b, wb_data;
    logic [ADDR_W-1:0] wb_a, pc_plus4, pc_next;
    logic [3:0]        wb_flags;
    logic              commit;

    assign wb_alu   = bypass ? f : alu_q;
    assign wb_b     = bypass ? b_mux : b_q;
    assign wb_a     = bypass ? a_rd[ADDR_W-1:0] : a_q;
    assign wb_flags = bypass ? flags_c : flags_q;
    assign commit   = (state_q == StWb) || bypass;
    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        wb_data = wb_alu;
        unique case (data_sel)
            2'd0: wb_data = wb_alu;
            2'd1: wb_data = wb_b;
            2'd2: wb_data = DATA_W'(pc_plus4);
            2'd3: wb_data = rdata_q;
        endcase
        pc_next = pc_q;
        unique case (pc_fs)
            2'b00: pc_next = pc_q;
            2'b01: pc_next = pc_plus4;
            2'b10: pc_next = pc_sel ? k_q : wb_a;
            2'b11: pc_next = pc_plus4 + (k_q << 2);
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cw_valid) state_d = StExec;
            StExec: begin
                if (mem_rd || mem_wr) state_d = StMemWait;
                else if (bypass)      state_d = StIdle;
                else                  state_d = StWb;
            end
            StMemWait: if (req_q && mem_ack) state_d = StWb;
            StWb:      state_d = StIdle;
        endcase
    end

    assign cw_ready  = (state_q == StIdle);
    assign done      = commit;
    assign mem_req   = req_q;
    assign mem_we    = req_q && mem_wr;
    assign mem_addr  = addr_sel ? alu_q[ADDR_W-1:0] : pc_q;
    assign mem_wdata = b_q;
    assign status    = status_q;
    assign IR_out    = ir_q;
    assign PC_out    = pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            cw_q     <= '0;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            flags_q  <= '0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            status_q <= '0;
            ir_q     <= '0;
            pc_q     <= '0;
            for (int i = 0; i < int'(REG_CNT); i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && cw_valid) begin
                cw_q <= cw;
                k_q  <= k;
            end
            if (state_q == StExec) begin
                a_q     <= a_rd[ADDR_W-1:0];
                b_q     <= b_mux;
                alu_q   <= f;
                flags_q <= flags_c;
            end
            // Request rises one cycle into MEM_WAIT and drops once acked.
            req_q <= (state_q == StMemWait) && !(req_q && mem_ack);
            if (state_q == StMemWait && req_q && mem_ack) rdata_q <= mem_rdata;
            if (commit) begin
                if (w_reg && da != XZR) regs_q[da] <= wb_data;
                if (ir_load) ir_q <= wb_data[31:0];
                if (st_load) status_q <= wb_flags;
                pc_q <= pc_next;
            end
        end
    end
endmodule
